// File: rtl/host_mem_responder.sv
// Host-side line-store responder for the processor's external memory interface.
// Optional read/write statistics counters are enabled by defining HOST_RESP_STATS_EN.
module host_mem_responder #(
    parameter int RD_LAT = 10,
    parameter int WR_LAT = 1,
    parameter int IDX_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [31:0]      io_addr,
    input  logic [511:0]     common_data_bus_out,
    output logic [511:0]     common_data_bus_in,
    output logic             tx_done,
    output logic             rd_valid,
    output logic             busy,
    input  logic             ld_en,
    input  logic [IDX_W+1:0] ld_idx,
    input  logic [511:0]     ld_data
`ifdef HOST_RESP_STATS_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count
`endif
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_WAIT  = 3'd1;
    localparam logic [2:0] RD_DONE  = 3'd2;
    localparam logic [2:0] RD_VALID = 3'd3;
    localparam logic [2:0] WR_WAIT  = 3'd4;
    localparam logic [2:0] WR_DONE  = 3'd5;
    localparam logic [2:0] WR_GAP   = 3'd6;

    localparam int CNT_W = 16;
    localparam int LINES = 4 << IDX_W;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W+1:0] idx_reg, idx_next;
    logic [511:0]     line_mem [LINES];
    logic [511:0]     rd_data_reg;
    logic             wr_fire;

    // Only the region and line-index fields of the address select a line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{io_addr[31:30], io_addr[27:IDX_W+6], io_addr[5:0]};

    assign wr_fire = (state_reg == WR_DONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (op == 2'b01) begin
                    state_next = RD_WAIT;
                    idx_next   = {io_addr[29:28], io_addr[IDX_W+5:6]};
                    cnt_next   = CNT_W'(RD_LAT - 1);
                end else if (op == 2'b11) begin
                    state_next = WR_WAIT;
                    idx_next   = {io_addr[29:28], io_addr[IDX_W+5:6]};
                    cnt_next   = CNT_W'(WR_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) state_next = RD_DONE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            RD_DONE:  state_next = RD_VALID;
            RD_VALID: state_next = IDLE;
            WR_WAIT: begin
                if (cnt_reg == '0) state_next = WR_DONE;
                else               cnt_next   = cnt_reg - 1'b1;
            end
            WR_DONE:  state_next = WR_GAP;
            WR_GAP:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            cnt_reg            <= '0;
            idx_reg            <= '0;
            tx_done            <= 1'b0;
            rd_valid           <= 1'b0;
            busy               <= 1'b0;
            common_data_bus_in <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            tx_done   <= (state_reg == RD_DONE) || (state_reg == WR_DONE);
            rd_valid  <= (state_reg == RD_VALID);
            busy      <= (state_next != IDLE);
            if (state_reg == RD_DONE) common_data_bus_in <= rd_data_reg;
        end
    end

    // Protocol write is issued last so it wins a same-edge, same-index backdoor collision.
    always_ff @(posedge clk) begin
        if (ld_en)   line_mem[ld_idx]  <= ld_data;
        if (wr_fire) line_mem[idx_reg] <= common_data_bus_out;
        rd_data_reg <= line_mem[idx_reg];
    end

`ifdef HOST_RESP_STATS_EN
    logic [1:0] stat_hit;
    assign stat_hit = {state_reg == WR_DONE, state_reg == RD_VALID};

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] count_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                count_reg <= '0;
            else if (stat_hit[gi] && count_reg != 16'hFFFF)
                count_reg <= count_reg + 1'b1;
        end
    end

    assign rd_count = g_stat[0].count_reg;
    assign wr_count = g_stat[1].count_reg;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
